rgb_to_gray: RTL



---
 rtl/rgb_to_gray.sv | 91 +++++++++
 1 files changed

// File: rtl/rgb_to_gray.sv
// Streaming RGB-to-grey converter: pops 24-bit RGB pixels from a FWFT FIFO,
// computes floor((R+G+B)*683/2048) in a 2-stage pipeline, pushes 8-bit grey.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_rd_en  (out)     pop strobe to the RGB input FIFO
//   in_empty  (in)      RGB input FIFO empty
//   in_dout   (in)      RGB pixel {R,G,B}, valid while in_empty=0
//   out_wr_en (out)     push strobe to the grey output FIFO
//   out_full  (in)      grey output FIFO full
//   out_din   (out)     grey pixel, valid while out_wr_en=1
//   frame_done(out)     one-cycle pulse after the last pixel of a frame
module rgb_to_gray #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic        in_empty,
    input  logic [23:0] in_dout,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [7:0]  out_din,
    output logic        frame_done
);

    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int CNT_W  = $clog2(PIXELS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS - 1);

    logic             v1_q;
    logic             v2_q;
    logic [9:0]       sum1_q;
    logic [9:0]       sum1_d;
    logic [7:0]       gray2_q;
    logic [7:0]       gray2_d;
    logic [CNT_W-1:0] cnt_q;
    logic             frame_done_q;
    logic             adv;

    // Stage 2 can take a new value when it is empty or being drained.
    assign adv       = ~v2_q | ~out_full;
    assign out_wr_en = v2_q & ~out_full;
    assign out_din   = v2_q ? gray2_q : 8'd0;
    assign in_rd_en  = ~in_empty & (~v1_q | adv);
    assign frame_done = frame_done_q;

    assign sum1_d = {2'b00, in_dout[23:16]}
                  + {2'b00, in_dout[15:8]}
                  + {2'b00, in_dout[7:0]};

    // 683/2048 approximates 1/3; the max sum 765 still maps to 255.
    assign gray2_d = 8'((20'(sum1_q) * 20'd683) >> 11);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            sum1_q       <= '0;
            gray2_q      <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (adv) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    gray2_q <= gray2_d;
                end
            end

            if (in_rd_en) begin
                sum1_q <= sum1_d;
                v1_q   <= 1'b1;
            end else if (adv) begin
                v1_q <= 1'b0;
            end

            frame_done_q <= 1'b0;
            if (out_wr_en) begin
                if (cnt_q == LAST) begin
                    cnt_q        <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule
